// File: rtl/ex_operand_ctrl.sv
// Execute-stage operand control: forwarding selects, load-use and RTI stalls,
// and flag-register write control for a 5-stage pipeline.
module ex_operand_ctrl #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_use_shamt,
  input  logic              id_rti,
  input  logic              id_flag_write,
  input  logic              flush,
  output logic [1:0]        alu_src1_select,
  output logic [1:0]        alu_src2_select,
  output logic              alu_src_select,
  output logic              flag_regsel,
  output logic              flagreg_enable,
  output logic              stall
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              reg_write;
    logic              mem_read;
    logic              use_rs1;
    logic              use_rs2;
    logic              use_shamt;
    logic              rti;
    logic              flag_write;
  } ex_slot_t;

  // MEM and WB only carry what forwarding and RTI flag restore look at.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              rti;
  } late_slot_t;

  typedef enum logic [1:0] {IDLE, LD_STALL, RTI_WAIT1, RTI_WAIT2} state_t;

  state_t     state_q, state_d;
  logic       ex_vld_q, mem_vld_q, wb_vld_q;
  ex_slot_t   ex_q, id_slot;
  late_slot_t mem_q, wb_q;
  logic       load_use, id_accept;

  function automatic logic [1:0] fwd_sel(
    input logic              use_src,
    input logic [REG_AW-1:0] rs,
    input logic              mem_hit_ok,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_hit_ok,
    input logic [REG_AW-1:0] wb_rd
  );
    if (use_src && mem_hit_ok && (mem_rd == rs)) return 2'b01;
    if (use_src && wb_hit_ok && (wb_rd == rs))   return 2'b00;
    return 2'b10;
  endfunction

  always_comb begin
    id_slot = '{rd: id_rd, rs1: id_rs1, rs2: id_rs2, reg_write: id_reg_write,
                mem_read: id_mem_read, use_rs1: id_use_rs1, use_rs2: id_use_rs2,
                use_shamt: id_use_shamt, rti: id_rti, flag_write: id_flag_write};
  end

  assign load_use = ex_vld_q && ex_q.mem_read && ex_q.reg_write && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A taken branch always releases the stall: the held ID instruction is dead.
  assign stall = !flush && (((state_q == IDLE) && load_use) ||
                            (state_q == RTI_WAIT1) || (state_q == RTI_WAIT2));

  assign id_accept = id_valid && !stall && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_use && !flush)      state_d = LD_STALL;
        else if (id_accept && id_rti) state_d = RTI_WAIT1;
      end
      LD_STALL:  state_d = (id_accept && id_rti) ? RTI_WAIT1 : IDLE;
      RTI_WAIT1: state_d = RTI_WAIT2;
      RTI_WAIT2: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ex_vld_q  <= 1'b0;
      mem_vld_q <= 1'b0;
      wb_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ex_vld_q  <= id_accept;
      mem_vld_q <= ex_vld_q;
      wb_vld_q  <= mem_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (id_accept) ex_q <= id_slot;
    mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write, rti: ex_q.rti};
    wb_q  <= mem_q;
  end

  always_comb begin
    alu_src1_select = 2'b10;
    alu_src2_select = 2'b10;
    alu_src_select  = 1'b1;
    if (ex_vld_q) begin
      alu_src1_select = fwd_sel(ex_q.use_rs1, ex_q.rs1,
                                mem_vld_q && mem_q.reg_write, mem_q.rd,
                                wb_vld_q && wb_q.reg_write, wb_q.rd);
      if (!ex_q.use_shamt)
        alu_src2_select = fwd_sel(ex_q.use_rs2, ex_q.rs2,
                                  mem_vld_q && mem_q.reg_write, mem_q.rd,
                                  wb_vld_q && wb_q.reg_write, wb_q.rd);
      alu_src_select = !ex_q.use_shamt;
    end
  end

  // RTI flag restore in WB wins over any ALU flag update in EX.
  assign flag_regsel    = wb_vld_q && wb_q.rti;
  assign flagreg_enable = flag_regsel || (ex_vld_q && ex_q.flag_write);

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Scoreboard bench for ex_operand_ctrl: directed program, then randomized traffic
// with mid-cycle resets, compared against an instruction-level pipeline model.
module tb_ex_operand_ctrl;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       reg_write;
    logic       mem_read;
    logic       use_shamt;
    logic       rti;
    logic       flag_write;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, flush = 1'b0;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_mem_read = 0;
  logic       id_use_shamt = 0, id_rti = 0, id_flag_write = 0;
  logic [1:0] alu_src1_select, alu_src2_select;
  logic       alu_src_select, flag_regsel, flagreg_enable, stall;

  always #5 clk = ~clk;

  ex_operand_ctrl #(.REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_use_shamt(id_use_shamt),
    .id_rti(id_rti), .id_flag_write(id_flag_write), .flush(flush),
    .alu_src1_select(alu_src1_select), .alu_src2_select(alu_src2_select),
    .alu_src_select(alu_src_select), .flag_regsel(flag_regsel),
    .flagreg_enable(flagreg_enable), .stall(stall)
  );

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; rti_left = stall cycles still owed to an RTI.
  ins_t       pipe [3];
  int         rti_left;
  logic [7:0] exp_q [$];
  int         checks = 0, failures = 0, resets_mid = 0;

  function automatic ins_t mk(input logic [2:0] rd, rs1, rs2,
                              input logic u1, u2, rw, mr, sh, rt, fw);
    ins_t i;
    i = '{valid: 1'b1, rd: rd, rs1: rs1, rs2: rs2, use_rs1: u1, use_rs2: u2,
          reg_write: rw, mem_read: mr, use_shamt: sh, rti: rt, flag_write: fw};
    return i;
  endfunction

  function automatic ins_t alu(input logic [2:0] rd, rs1, rs2);
    return mk(rd, rs1, rs2, 1, 1, 1, 0, 0, 0, 1);
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i = mk(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 15) == 0), 1'($urandom));
    i.valid = ($urandom_range(0, 9) != 0);
    return i;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    rti_left = 0;
  endfunction

  // Newest older writer of r wins: MEM (01), then WB (00), else register file (10).
  function automatic logic [1:0] src_for(input logic use_it, input logic [2:0] r);
    if (!use_it) return 2'b10;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].valid && pipe[k].reg_write && pipe[k].rd == r)
        return (k == 1) ? 2'b01 : 2'b00;
    return 2'b10;
  endfunction

  function automatic logic [7:0] expect_out(input ins_t id, input logic fl);
    ins_t ex;
    logic [1:0] s1, s2;
    logic lu, st, rsel, en, src;
    ex   = pipe[0];
    s1   = ex.valid ? src_for(ex.use_rs1, ex.rs1) : 2'b10;
    s2   = (ex.valid && !ex.use_shamt) ? src_for(ex.use_rs2, ex.rs2) : 2'b10;
    lu   = ex.valid && ex.mem_read && ex.reg_write && id.valid &&
           ((id.use_rs1 && id.rs1 == ex.rd) || (id.use_rs2 && id.rs2 == ex.rd));
    st   = !fl && (rti_left > 0 || lu);
    rsel = pipe[2].valid && pipe[2].rti;
    en   = rsel || (ex.valid && ex.flag_write);
    src  = !(ex.valid && ex.use_shamt);
    return {s1, s2, src, rsel, en, st};
  endfunction

  function automatic void advance(input ins_t id, input logic fl, input logic st);
    logic acc;
    acc = id.valid && !st && !fl;
    if (rti_left > 0) rti_left--;
    else if (acc && id.rti) rti_left = 2;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = acc ? id : '0;
  endfunction

  task automatic drive_cycle(input ins_t ins, input logic fl, input logic rst_lo,
                             output logic st_o);
    logic [7:0] e;
    @(posedge clk);
    #1;
    rst_n = !rst_lo;
    id_valid = ins.valid; id_rd = ins.rd; id_rs1 = ins.rs1; id_rs2 = ins.rs2;
    id_use_rs1 = ins.use_rs1; id_use_rs2 = ins.use_rs2; id_reg_write = ins.reg_write;
    id_mem_read = ins.mem_read; id_use_shamt = ins.use_shamt; id_rti = ins.rti;
    id_flag_write = ins.flag_write; flush = fl;
    if (rst_lo) model_reset();
    e = expect_out(ins, fl);
    exp_q.push_back(e);
    st_o = e[0];
    if (!rst_lo) advance(ins, fl, st_o);
  endtask

  initial begin : monitor
    logic [7:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {alu_src1_select, alu_src2_select, alu_src_select, flag_regsel,
             flagreg_enable, stall};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t {src1,src2,src,regsel,fen,stall} actual=%b required=%b",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    ins_t prog [$];
    ins_t cur, nop;
    logic st;
    int   idx;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    drive_cycle(nop, 0, 1, st);
    drive_cycle(nop, 0, 1, st);

    prog.push_back(alu(1, 2, 3));  prog.push_back(alu(2, 1, 3));
    prog.push_back(alu(1, 0, 0));  prog.push_back(nop);
    prog.push_back(alu(4, 5, 1));
    prog.push_back(alu(1, 2, 3));  prog.push_back(alu(1, 2, 3));
    prog.push_back(alu(4, 5, 1));
    prog.push_back(mk(2, 0, 0, 1, 0, 1, 1, 0, 0, 0)); prog.push_back(alu(6, 2, 2));
    prog.push_back(alu(3, 1, 1));
    prog.push_back(mk(3, 3, 0, 1, 0, 1, 0, 1, 0, 1));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); prog.push_back(alu(1, 2, 3));
    prog.push_back(alu(0, 0, 0));  prog.push_back(alu(5, 0, 0));
    prog.push_back(nop);           prog.push_back(nop);
    idx = 0;
    while (idx < prog.size()) begin
      drive_cycle(prog[idx], 0, 0, st);
      if (!st) idx++;
    end

    // Load-use stall cut by a mid-cycle reset, then traffic resumes right away.
    drive_cycle(mk(2, 0, 0, 1, 0, 1, 1, 0, 0, 0), 0, 0, st);
    drive_cycle(alu(6, 2, 2), 0, 0, st);
    drive_cycle(alu(6, 2, 2), 0, 1, st);
    drive_cycle(alu(6, 2, 2), 0, 0, st);
    drive_cycle(alu(7, 6, 6), 0, 0, st);

    cur = rand_ins();
    st  = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (st && (resets_mid < 2 || $urandom_range(0, 19) == 0)) begin
        resets_mid++;
        drive_cycle(cur, 0, 1, st);
        drive_cycle(cur, 0, 1, st);
        cur = rand_ins();
      end else begin
        if (!st) cur = rand_ins();
        drive_cycle(cur, ($urandom_range(0, 19) == 0), 0, st);
      end
    end

    drive_cycle(nop, 0, 0, st);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
